// File: rtl/neural_acq_multich_frontend_if.sv
// Decimated-sample stream towards the framer: show-ahead head plus valid/ready handshake.
interface neural_acq_multich_frontend_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CH_ID_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]  acq_data;
  logic [CH_ID_WIDTH-1:0] acq_channel;
  logic                   acq_valid;
  logic                   acq_ready;

  modport master (output acq_data, output acq_channel, output acq_valid, input acq_ready);
  modport slave  (input acq_data, input acq_channel, input acq_valid, output acq_ready);
endinterface

// File: rtl/neural_acq_multich_frontend.sv
// Multi-channel acquisition front end: channel mask, per-channel power-of-two boxcar
// decimation, and a show-ahead output FIFO with sticky overflow and drop counting.
module neural_acq_multich_frontend #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned CH_ID_WIDTH    = 4,
  parameter int unsigned NUM_CH         = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned DECIM_MAX_LOG2 = 3,
  localparam int unsigned D_W           = $clog2(DECIM_MAX_LOG2 + 1),
  localparam int unsigned LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   sensor_clk,
  input  logic                   sensor_rst_n,
  input  logic [DATA_WIDTH-1:0]  adc_data_in,
  input  logic [CH_ID_WIDTH-1:0] adc_channel_in,
  input  logic                   adc_valid_in,
  input  logic [NUM_CH-1:0]      cfg_ch_enable,
  input  logic [D_W-1:0]         cfg_decim_log2,
  input  logic                   cfg_ovf_clear,
  neural_acq_multich_frontend_if.master acq,
  output logic [LVL_W-1:0]       fifo_level,
  output logic                   overflow,
  output logic [15:0]            drop_count
);
  localparam int unsigned ACC_W    = DATA_WIDTH + DECIM_MAX_LOG2;
  localparam int unsigned CNT_W    = (DECIM_MAX_LOG2 > 0) ? DECIM_MAX_LOG2 : 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CH_SPACE = 2 ** CH_ID_WIDTH;

  logic [CH_SPACE-1:0]    w_en_ext;
  logic                   w_s1_take;
  logic                   r_s1_valid;
  logic [DATA_WIDTH-1:0]  r_s1_data;
  logic [CH_ID_WIDTH-1:0] r_s1_ch;

  // Enable mask widened to the full channel-ID space so out-of-range IDs index safely.
  assign w_en_ext  = CH_SPACE'(cfg_ch_enable);
  assign w_s1_take = adc_valid_in && (32'(adc_channel_in) < NUM_CH) && w_en_ext[adc_channel_in];

  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_ch    <= '0;
    end else begin
      r_s1_valid <= w_s1_take;
      if (w_s1_take) begin
        r_s1_data <= adc_data_in;
        r_s1_ch   <= adc_channel_in;
      end
    end
  end

  logic [D_W-1:0]          r_d;
  logic [D_W-1:0]          w_d_sat;
  logic [D_W-1:0]          w_d_eff;
  logic                    w_d_change;
  logic signed [ACC_W-1:0] r_acc [NUM_CH];
  logic [CNT_W-1:0]        r_cnt [NUM_CH];
  logic signed [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0]        w_cnt_base;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_last;
  logic                    w_s2_fire;
  logic [DATA_WIDTH-1:0]   w_result;
  logic                    r_res_valid;
  logic [DATA_WIDTH-1:0]   r_res_data;
  logic [CH_ID_WIDTH-1:0]  r_res_ch;

  // A new exponent restarts every block, so the sample seen in that cycle starts from zero.
  assign w_d_sat    = (32'(cfg_decim_log2) > DECIM_MAX_LOG2) ? D_W'(DECIM_MAX_LOG2) : cfg_decim_log2;
  assign w_d_change = (w_d_sat != r_d);
  assign w_d_eff    = w_d_change ? w_d_sat : r_d;
  assign w_acc_base = w_d_change ? '0 : r_acc[r_s1_ch];
  assign w_cnt_base = w_d_change ? '0 : r_cnt[r_s1_ch];
  assign w_sum      = w_acc_base + ACC_W'($signed(r_s1_data));
  assign w_last     = (w_cnt_base == CNT_W'((1 << w_d_eff) - 1));
  assign w_result   = DATA_WIDTH'(w_sum >>> w_d_eff);
  assign w_s2_fire  = r_s1_valid && w_en_ext[r_s1_ch];

  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      r_d         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ch    <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        r_acc[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      r_d         <= w_d_sat;
      r_res_valid <= w_s2_fire && w_last;
      if (w_s2_fire && w_last) begin
        r_res_data <= w_result;
        r_res_ch   <= r_s1_ch;
      end
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (w_d_change || !cfg_ch_enable[c]) begin
          r_acc[c] <= '0;
          r_cnt[c] <= '0;
        end
      end
      if (w_s2_fire) begin
        if (w_last) begin
          r_acc[r_s1_ch] <= '0;
          r_cnt[r_s1_ch] <= '0;
        end else begin
          r_acc[r_s1_ch] <= w_sum;
          r_cnt[r_s1_ch] <= w_cnt_base + CNT_W'(1);
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0]  r_mem_data [FIFO_DEPTH];
  logic [CH_ID_WIDTH-1:0] r_mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       w_rd_nxt;
  logic [LVL_W-1:0]       r_level;
  logic [LVL_W-1:0]       w_level_nxt;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_head_data;
  logic [CH_ID_WIDTH-1:0] r_head_ch;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push_ok;
  logic                   w_drop;
  logic                   w_head_from_push;

  assign w_pop            = r_valid && acq.acq_ready;
  assign w_full           = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push_ok        = r_res_valid && (!w_full || w_pop);
  assign w_drop           = r_res_valid && w_full && !w_pop;
  assign w_level_nxt      = r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
  assign w_rd_nxt         = r_rd_ptr + PTR_W'(1);
  assign w_head_from_push = w_push_ok && ((r_level == '0) || (w_pop && (r_level == LVL_W'(1))));

  always_ff @(posedge sensor_clk) begin
    if (w_push_ok) begin
      r_mem_data[r_wr_ptr] <= r_res_data;
      r_mem_ch[r_wr_ptr]   <= r_res_ch;
    end
  end

  // Head is kept in its own register so the framer sees flop outputs; it bypasses the
  // array when the entry being written is also the next one to be shown.
  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_valid     <= 1'b0;
      r_head_data <= '0;
      r_head_ch   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= w_rd_nxt;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      if (w_head_from_push) begin
        r_head_data <= r_res_data;
        r_head_ch   <= r_res_ch;
      end else if (w_pop) begin
        r_head_data <= r_mem_data[w_rd_nxt];
        r_head_ch   <= r_mem_ch[w_rd_nxt];
      end
    end
  end

  // A clear outranks a simultaneous drop.
  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (cfg_ovf_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign acq.acq_data    = r_head_data;
  assign acq.acq_channel = r_head_ch;
  assign acq.acq_valid   = r_valid;
  assign fifo_level      = r_level;
endmodule

// File: tb/tb_neural_acq_multich_frontend.sv
// Scoreboard bench for neural_acq_multich_frontend, built with NUM_CH=12 so that
// out-of-range channel IDs can be exercised.
module tb_neural_acq_multich_frontend;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] adc_data = '0;
  logic [3:0]  adc_ch = '0;
  logic        adc_valid = 1'b0;
  logic [11:0] mask = '0;
  logic [1:0]  decim = '0;
  logic        ovf_clr = 1'b0;
  logic [3:0]  level;
  logic        ovf;
  logic [15:0] drops;

  int total = 0;
  int bad = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  always #5 clk = ~clk;

  neural_acq_multich_frontend_if #(.DATA_WIDTH(16), .CH_ID_WIDTH(4)) acq_if ();

  neural_acq_multich_frontend #(
    .DATA_WIDTH(16), .CH_ID_WIDTH(4), .NUM_CH(12), .FIFO_DEPTH(8), .DECIM_MAX_LOG2(3)
  ) dut (
    .sensor_clk(clk), .sensor_rst_n(rst_n),
    .adc_data_in(adc_data), .adc_channel_in(adc_ch), .adc_valid_in(adc_valid),
    .cfg_ch_enable(mask), .cfg_decim_log2(decim), .cfg_ovf_clear(ovf_clr),
    .acq(acq_if), .fifo_level(level), .overflow(ovf), .drop_count(drops)
  );

  // Every accepted output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && acq_if.acq_valid && acq_if.acq_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_unexpected got=(%h,ch%0d) want=nothing", acq_if.acq_data, acq_if.acq_channel);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({acq_if.acq_channel, acq_if.acq_data} !== mon_exp) begin
          bad++;
          $display("FAIL stream_data got=(%h,ch%0d) want=(%h,ch%0d)",
                   acq_if.acq_data, acq_if.acq_channel, mon_exp[15:0], mon_exp[19:16]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ch, input logic [15:0] d);
    adc_valid = 1'b1;
    adc_ch    = ch;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] d, input logic [11:0] m);
    decim = d;
    mask  = m;
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !acq_if.acq_valid) break;
      tick();
    end
    total++;
    if (exp_q.size() != 0 || acq_if.acq_valid) begin
      bad++;
      $display("FAIL %s_drain got=%0d_pending want=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++;
    if ({acq_if.acq_data, acq_if.acq_channel, acq_if.acq_valid, level, ovf, drops} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%0d/%b/%0d/%b/%0d want=all_zero",
               acq_if.acq_data, acq_if.acq_channel, acq_if.acq_valid, level, ovf, drops);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    acq_if.acq_ready = 1'b1;
    set_cfg(2'd0, 12'hFFF);
    exp_q.push_back({4'd3, 16'h1234});
    exp_q.push_back({4'd7, 16'h8000});
    drive(4'd3, 16'h1234);
    drive(4'd7, 16'h8000);
    total++;
    if (acq_if.acq_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got=%b want=0", acq_if.acq_valid);
    end
    tick();
    total++;
    if ({acq_if.acq_valid, acq_if.acq_channel, acq_if.acq_data} !== {1'b1, 4'd3, 16'h1234}) begin
      bad++;
      $display("FAIL latency_head got=(%b,%h,ch%0d) want=(1,1234,ch3)",
               acq_if.acq_valid, acq_if.acq_data, acq_if.acq_channel);
    end
    wait_drain("passthrough");
  endtask

  task automatic test_decim();
    set_cfg(2'd2, 12'hFFF);
    exp_q.push_back({4'd5, 16'h0008});
    drive(4'd5, 16'd10);
    drive(4'd5, 16'd11);
    drive(4'd5, 16'd12);
    drive(4'd5, 16'hFFFF);
    wait_drain("decim_full");
    drive(4'd5, 16'd4);
    drive(4'd5, 16'd4);
    drive(4'd5, 16'd4);
    repeat (6) tick();
    total++;
    if (level !== 4'd0 || acq_if.acq_valid !== 1'b0) begin
      bad++;
      $display("FAIL decim_partial got=level%0d want=level0", level);
    end
  endtask

  task automatic test_mask();
    set_cfg(2'd0, 12'hFFB);
    drive(4'd2, 16'h0055);
    drive(4'd15, 16'h0066);
    repeat (5) tick();
    total++;
    if (level !== 4'd0 || drops !== 16'd0) begin
      bad++;
      $display("FAIL mask_discard got=level%0d,drops%0d want=level0,drops0", level, drops);
    end
    set_cfg(2'd1, 12'hFFF);
    drive(4'd1, 16'd100);
    mask = 12'hFFD;
    repeat (2) tick();
    mask = 12'hFFF;
    tick();
    exp_q.push_back({4'd1, 16'd7});
    drive(4'd1, 16'd6);
    drive(4'd1, 16'd8);
    wait_drain("mask_reenable");
  endtask

  task automatic test_overflow();
    acq_if.acq_ready = 1'b0;
    set_cfg(2'd0, 12'hFFF);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back({4'(i), 16'h0100 + 16'(i)});
      drive(4'(i), 16'h0100 + 16'(i));
    end
    repeat (3) tick();
    total++;
    if (level !== 4'd8 || ovf !== 1'b1 || drops !== 16'd2) begin
      bad++;
      $display("FAIL overflow_state got=level%0d,ovf%b,drops%0d want=level8,ovf1,drops2", level, ovf, drops);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({4'd5, 16'hBEEF});
    drive(4'd5, 16'hBEEF);
    tick();
    acq_if.acq_ready = 1'b1;
    tick();
    acq_if.acq_ready = 1'b0;
    total++;
    if (level !== 4'd8 || drops !== 16'd2) begin
      bad++;
      $display("FAIL full_push_pop got=level%0d,drops%0d want=level8,drops2", level, drops);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0 || drops !== 16'd0) begin
      bad++;
      $display("FAIL ovf_clear got=ovf%b,drops%0d want=ovf0,drops0", ovf, drops);
    end
    acq_if.acq_ready = 1'b1;
    wait_drain("overflow");
  endtask

  task automatic test_decim_change();
    set_cfg(2'd2, 12'hFFF);
    drive(4'd0, 16'd1);
    drive(4'd0, 16'd2);
    drive(4'd0, 16'd3);
    tick();
    decim = 2'd1;
    tick();
    exp_q.push_back({4'd0, 16'd3});
    drive(4'd0, 16'd2);
    drive(4'd0, 16'd4);
    wait_drain("decim_change");
  endtask

  task automatic test_reset_mid();
    acq_if.acq_ready = 1'b0;
    set_cfg(2'd0, 12'hFFF);
    drive(4'd1, 16'h1111);
    drive(4'd2, 16'h2222);
    drive(4'd3, 16'h3333);
    repeat (3) tick();
    total++;
    if (level !== 4'd3) begin
      bad++;
      $display("FAIL midreset_fill got=level%0d want=level3", level);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({acq_if.acq_data, acq_if.acq_channel, acq_if.acq_valid, level, ovf, drops} !== 42'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h/%0d/%b/%0d/%b/%0d want=all_zero",
               acq_if.acq_data, acq_if.acq_channel, acq_if.acq_valid, level, ovf, drops);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    acq_if.acq_ready = 1'b0;
    test_reset();
    test_passthrough();
    test_decim();
    test_mask();
    test_overflow();
    test_back_to_back();
    test_decim_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
